// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stalls, branch flushes,
// data-cache freezes and the sticky halt latch. Define HAZARD_PERF_EN to add stall/flush counters.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_done,
    input  logic        ex_mem_to_reg,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        branch_taken,
    input  logic        halted_wire,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
    output logic        halted,
    output logic [2:0]  hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LOAD_STALL = 3'd1,
        MEM_WAIT   = 3'd2,
        FLUSH      = 3'd3,
        HALT       = 3'd4
    } hz_state_t;

    hz_state_t state;
    logic      pend_flush;
    logic      lu;

    assign lu = ex_mem_to_reg && ex_reg_write && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A branch taken in RUN/LOAD_STALL is flushed in the same cycle, so only branches
    // that arrive while the pipe is frozen are deferred into the FLUSH state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            pend_flush <= 1'b0;
        end else if (state != HALT) begin
            if (halted_wire) begin
                state <= HALT;
            end else if (cache_done) begin
                state <= MEM_WAIT;
                if (branch_taken)
                    pend_flush <= 1'b1;
            end else if (pend_flush || (branch_taken && state == MEM_WAIT)) begin
                state      <= FLUSH;
                pend_flush <= 1'b0;
            end else if (lu && state == RUN && !branch_taken) begin
                state <= LOAD_STALL;
            end else begin
                state <= RUN;
            end
        end
    end

    // Freeze outranks flush, and flush outranks the load-use bubble.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == HALT) begin
            halted = 1'b1;
        end else if (cache_done || state == MEM_WAIT) begin
            pipe_freeze = 1'b1;
        end else if (state == FLUSH || branch_taken) begin
            pc_write     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state == RUN && lu) begin
            id_ex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    assign hz_state = state;

`ifdef HAZARD_PERF_EN
    // Saturating counters; the reset branch keeps reset-time flushes out of the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!pc_write && state != HALT && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; counter checks are compiled in
// only when HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       cache_done;
        logic       ex_mem_to_reg;
        logic       ex_reg_write;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       branch_taken;
        logic       halted_wire;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [5:0] exp_out;
        logic [2:0] exp_next;
    } vec_t;

    localparam logic [2:0] S_RUN = 3'd0, S_LS = 3'd1, S_MW = 3'd2, S_FL = 3'd3, S_HALT = 3'd4;
    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted}
    localparam logic [5:0] O_RUN = 6'b110000, O_LU = 6'b000100, O_FLUSH = 6'b101100,
                           O_FRZ = 6'b000010, O_HALT = 6'b000001, O_RST = 6'b001100;

    logic        clk, rst, cache_done, ex_mem_to_reg, ex_reg_write;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        id_uses_rt, branch_taken, halted_wire;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted;
    logic [2:0]  hz_state;
    logic [5:0]  outs;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    stim_t IDLE, LW5, CD, CD_BR, HW;
    vec_t  vecs[13];

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .cache_done(cache_done),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .branch_taken(branch_taken), .halted_wire(halted_wire),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .halted(halted),
        .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic cd, logic mtr, logic rw, logic [4:0] ert,
                                 logic [4:0] rs, logic [4:0] rt, logic urt, logic br, logic hw);
        return '{cd, mtr, rw, ert, rs, rt, urt, br, hw};
    endfunction

    task automatic applyStimulus(input stim_t s);
        cache_done    = s.cache_done;
        ex_mem_to_reg = s.ex_mem_to_reg;
        ex_reg_write  = s.ex_reg_write;
        ex_rt         = s.ex_rt;
        id_rs         = s.id_rs;
        id_rt         = s.id_rt;
        id_uses_rt    = s.id_uses_rt;
        branch_taken  = s.branch_taken;
        halted_wire   = s.halted_wire;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: drive one cycle, check state and outputs, advance to the next falling edge.
    task automatic stepCheck(input string name, input stim_t s, input logic [5:0] exp_out, input logic [2:0] exp_state);
        applyStimulus(s);
        #1;
        checkOutput({name, " state"}, {29'd0, hz_state}, {29'd0, exp_state});
        checkOutput({name, " outs"}, {26'd0, outs}, {26'd0, exp_out});
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(IDLE);
        #1;
        checkOutput("reset outs", {26'd0, outs}, {26'd0, O_RST});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        IDLE  = mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        LW5   = mk(0, 1, 1, 5'd5, 5'd5, 5'd2, 1, 0, 0);
        CD    = mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        CD_BR = mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        HW    = mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);

        vecs[0]  = '{"idle",          IDLE,                                 O_RUN,   S_RUN};
        vecs[1]  = '{"lu rs",         LW5,                                  O_LU,    S_LS};
        vecs[2]  = '{"lu r0",         mk(0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0), O_RUN,   S_RUN};
        vecs[3]  = '{"rt no use",     mk(0, 1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0), O_RUN,   S_RUN};
        vecs[4]  = '{"lu rt",         mk(0, 1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0), O_LU,    S_LS};
        vecs[5]  = '{"no regwrite",   mk(0, 1, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0), O_RUN,   S_RUN};
        vecs[6]  = '{"not load",      mk(0, 0, 1, 5'd5, 5'd5, 5'd5, 1, 0, 0), O_RUN,   S_RUN};
        vecs[7]  = '{"branch",        mk(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0), O_FLUSH, S_RUN};
        vecs[8]  = '{"branch+lu",     mk(0, 1, 1, 5'd7, 5'd7, 5'd0, 0, 1, 0), O_FLUSH, S_RUN};
        vecs[9]  = '{"cache",         CD,                                   O_FRZ,   S_MW};
        vecs[10] = '{"cache+lu",      mk(1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0), O_FRZ,   S_MW};
        vecs[11] = '{"halt",          HW,                                   O_RUN,   S_HALT};
        vecs[12] = '{"halt+cache",    mk(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1), O_FRZ,   S_HALT};

        for (int i = 0; i < 13; i++) begin
            doReset();
            stepCheck(vecs[i].name, vecs[i].s, vecs[i].exp_out, S_RUN);
            checkOutput({vecs[i].name, " next"}, {29'd0, hz_state}, {29'd0, vecs[i].exp_next});
        end

        // Load-use: exactly one stall cycle, and the same load does not stall twice.
        doReset();
        stepCheck("lu stall",   LW5,  O_LU,  S_RUN);
        stepCheck("lu release", LW5,  O_RUN, S_LS);
        stepCheck("lu resume",  IDLE, O_RUN, S_RUN);
`ifdef HAZARD_PERF_EN
        checkOutput("lu stall_cycles", stall_cycles, 32'd1);
`endif

        // Cache miss with a branch in cycle 2: freeze, exit cycle, then one deferred FLUSH.
        doReset();
        stepCheck("mw c1",    CD,    O_FRZ,   S_RUN);
        stepCheck("mw c2",    CD_BR, O_FRZ,   S_MW);
        stepCheck("mw c3",    CD,    O_FRZ,   S_MW);
        stepCheck("mw c4",    CD,    O_FRZ,   S_MW);
        stepCheck("mw exit",  IDLE,  O_FRZ,   S_MW);
        stepCheck("mw flush", IDLE,  O_FLUSH, S_FL);
        stepCheck("mw after", IDLE,  O_RUN,   S_RUN);
`ifdef HAZARD_PERF_EN
        checkOutput("mw flush_count", {16'd0, flush_count}, 32'd1);
        checkOutput("mw stall_cycles", stall_cycles, 32'd5);
`endif

        // Halt is sticky against toggling inputs until reset.
        doReset();
        stepCheck("halt pulse", HW, O_RUN, S_RUN);
        for (int i = 0; i < 4; i++)
            stepCheck("halt hold", (i % 2 == 0) ? CD_BR : LW5, O_HALT, S_HALT);
        doReset();
        stepCheck("post halt", IDLE, O_RUN, S_RUN);

        // Reset during MEM_WAIT with a pending flush drops the flush.
        doReset();
        stepCheck("rw c1", CD_BR, O_FRZ, S_RUN);
        stepCheck("rw c2", CD,    O_FRZ, S_MW);
        doReset();
        stepCheck("rw r1", IDLE, O_RUN, S_RUN);
        stepCheck("rw r2", IDLE, O_RUN, S_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
